// File: rtl/in_fm_fifo_to_tile_buf_pkg.sv
// Shared definitions for the in_fm FIFO to input tile buffer loader:
// FSM encoding, default tile geometry and width helpers.
package in_fm_fifo_to_tile_buf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_TM     = 8;
  localparam int DEF_TR     = 16;
  localparam int DEF_TC     = 8;
  localparam int TILE_WORDS = DEF_TM * DEF_TR * DEF_TC;

  // Ceiling log2, never below 1 so single-entry dimensions still get a bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int tile_words(input int tm, input int tr, input int tc);
    return tm * tr * tc;
  endfunction

endpackage

// File: rtl/in_fm_fifo_to_tile_buf_nest3_counter.sv
// Three-level nested index counter (cnt0 fastest). done flags the write
// that wraps the whole index back to zero.
module nest3_counter
  import in_fm_fifo_to_tile_buf_pkg::*;
#(
  parameter int L0 = 8,
  parameter int L1 = 16,
  parameter int L2 = 8,
  parameter int W0 = clog2(L0),
  parameter int W1 = clog2(L1),
  parameter int W2 = clog2(L2)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          clean,
  output logic [W0-1:0] cnt0,
  output logic [W1-1:0] cnt1,
  output logic [W2-1:0] cnt2,
  output logic          done
);

  logic last0, last1, last2;

  assign last0 = (cnt0 == W0'(L0 - 1));
  assign last1 = (cnt1 == W1'(L1 - 1));
  assign last2 = (cnt2 == W2'(L2 - 1));
  assign done  = ena && last0 && last1 && last2;

  always_ff @(posedge clk) begin
    if (rst || clean) begin
      cnt0 <= '0;
      cnt1 <= '0;
      cnt2 <= '0;
    end else if (ena) begin
      if (last0) begin
        cnt0 <= '0;
        if (last1) begin
          cnt1 <= '0;
          cnt2 <= last2 ? '0 : cnt2 + 1'b1;
        end else begin
          cnt1 <= cnt1 + 1'b1;
        end
      end else begin
        cnt0 <= cnt0 + 1'b1;
      end
    end
  end

endmodule

// File: rtl/in_fm_fifo_to_tile_buf.sv
// Pops one Tm*Tr*Tc input tile from the in_fm FIFO and scatters it into the
// banked tile buffer (bank = tm, address = tr*Tc+tc), then holds done.
module in_fm_fifo_to_tile_buf
  import in_fm_fifo_to_tile_buf_pkg::*;
#(
  parameter int CW  = 32,
  parameter int DW  = 32,
  parameter int Tm  = 8,
  parameter int Tr  = 16,
  parameter int Tc  = 8,
  parameter int BW  = clog2(Tm),
  parameter int BAW = clog2(Tr * Tc)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           conv_tile_clean,
  output logic           done,
  output logic           fifo_pop,
  input  logic           fifo_empty,
  input  logic [DW-1:0]  data_from_fifo,
  output logic           buf_wr_ena,
  output logic [BW-1:0]  buf_wr_bank,
  output logic [BAW-1:0] buf_wr_addr,
  output logic [DW-1:0]  buf_wr_data
);

  localparam logic [CW-1:0] TILE_CNT = CW'(tile_words(Tm, Tr, Tc));
  localparam int TCW = clog2(Tc);
  localparam int TRW = clog2(Tr);
  localparam int TMW = clog2(Tm);

  state_t          state;
  logic [CW-1:0]   pop_cnt;
  logic            pop_q;
  logic            rd_valid;
  logic [DW-1:0]   rd_data;
  logic [TCW-1:0]  tc_cnt;
  logic [TRW-1:0]  tr_cnt;
  logic [TMW-1:0]  tm_cnt;
  logic            wr_last;
  logic            start_ok;

  // A start pulse mid-tile must not disturb the counters, so it is qualified.
  assign start_ok = start && ((state == IDLE) || (state == DONE));
  assign fifo_pop = (state == RUN) && !fifo_empty && (pop_cnt < TILE_CNT);

  assign buf_wr_ena  = rd_valid;
  assign buf_wr_data = rd_data;
  assign buf_wr_bank = BW'(tm_cnt);
  assign buf_wr_addr = BAW'(int'(tr_cnt) * Tc + int'(tc_cnt));

  nest3_counter #(
    .L0 (Tc),
    .L1 (Tr),
    .L2 (Tm)
  ) u_wr_index (
    .clk   (clk),
    .rst   (rst),
    .ena   (buf_wr_ena),
    .clean (start_ok),
    .cnt0  (tc_cnt),
    .cnt1  (tr_cnt),
    .cnt2  (tm_cnt),
    .done  (wr_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      done     <= 1'b0;
      pop_cnt  <= '0;
      pop_q    <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      pop_q    <= fifo_pop;
      rd_valid <= pop_q;
      if (pop_q) rd_data <= data_from_fifo;

      if (start_ok)      pop_cnt <= '0;
      else if (fifo_pop) pop_cnt <= pop_cnt + 1'b1;

      // start beats conv_tile_clean when both arrive in DONE.
      case (state)
        IDLE:  if (start) state <= RUN;
        RUN:   if (pop_cnt == TILE_CNT) state <= DRAIN;
        DRAIN: if (wr_last) begin
                 state <= DONE;
                 done  <= 1'b1;
               end
        DONE:  if (start) begin
                 state <= RUN;
                 done  <= 1'b0;
               end else if (conv_tile_clean) begin
                 state <= IDLE;
                 done  <= 1'b0;
               end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_in_fm_fifo_to_tile_buf.sv
// Scoreboard bench for in_fm_fifo_to_tile_buf with a 2x2x2 tile and a
// behavioural FIFO that can be forced empty on alternate cycles.
module tb_in_fm_fifo_to_tile_buf;

  localparam int TM = 2;
  localparam int TR = 2;
  localparam int TC = 2;
  localparam int WORDS = TM * TR * TC;
  localparam int BANK_WORDS = TR * TC;

  typedef struct {
    int bank;
    int addr;
    int data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        conv_tile_clean = 1'b0;
  logic        done;
  logic        fifo_pop;
  logic        fifo_empty;
  logic [31:0] data_from_fifo = '0;
  logic        buf_wr_ena;
  logic [0:0]  buf_wr_bank;
  logic [1:0]  buf_wr_addr;
  logic [31:0] buf_wr_data;

  logic [31:0] mem [0:1023];
  logic [9:0]  rd_ptr = '0;
  logic [9:0]  wr_ptr = '0;
  logic        stall = 1'b0;
  logic        stall_en = 1'b0;
  logic        fifo_flush = 1'b0;

  int   checks = 0;
  int   failures = 0;
  int   pops = 0;
  int   writes = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  in_fm_fifo_to_tile_buf #(
    .CW (32),
    .DW (32),
    .Tm (TM),
    .Tr (TR),
    .Tc (TC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .conv_tile_clean (conv_tile_clean),
    .done            (done),
    .fifo_pop        (fifo_pop),
    .fifo_empty      (fifo_empty),
    .data_from_fifo  (data_from_fifo),
    .buf_wr_ena      (buf_wr_ena),
    .buf_wr_bank     (buf_wr_bank),
    .buf_wr_addr     (buf_wr_addr),
    .buf_wr_data     (buf_wr_data)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (rd_ptr == wr_ptr) || stall;

  always @(posedge clk) begin
    if (fifo_flush) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_pop && (rd_ptr != wr_ptr)) begin
      data_from_fifo <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 10'd1;
    end
  end

  always @(negedge clk) stall <= stall_en ? ~stall : 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Monitor: counts pops, guards against popping an empty FIFO and scores writes.
  always begin
    @(posedge clk);
    #1;
    if (fifo_pop === 1'b1) pops++;
    if (fifo_empty) checkOutput("pop_while_empty", 32'(fifo_pop), 32'd0);
    if (buf_wr_ena === 1'b1) begin
      writes++;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_write", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("wr_bank", 32'(buf_wr_bank), mon_e.bank);
        checkOutput("wr_addr", 32'(buf_wr_addr), mon_e.addr);
        checkOutput("wr_data", buf_wr_data, mon_e.data);
      end
    end
  end

  task automatic preload(input int base, input int extra);
    for (int i = 0; i < WORDS; i++) begin
      mem[wr_ptr] = 32'(base + i);
      wr_ptr = wr_ptr + 10'd1;
      exp_q.push_back('{bank: i / BANK_WORDS, addr: i % BANK_WORDS, data: base + i});
    end
    for (int i = 0; i < extra; i++) begin
      mem[wr_ptr] = 32'hDEAD_0000 + 32'(i);
      wr_ptr = wr_ptr + 10'd1;
    end
  endtask

  task automatic flushFifo();
    fifo_flush = 1'b1;
    @(negedge clk);
    fifo_flush = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_pop"}, 32'(fifo_pop), 32'd0);
    checkOutput({tag, "_wr_ena"}, 32'(buf_wr_ena), 32'd0);
    checkOutput({tag, "_wr_bank"}, 32'(buf_wr_bank), 32'd0);
    checkOutput({tag, "_wr_addr"}, 32'(buf_wr_addr), 32'd0);
    checkOutput({tag, "_wr_data"}, buf_wr_data, 32'd0);
  endtask

  // Runs one tile: start (optionally with conv_tile_clean), optional spurious
  // start after spur_at pops, then checks done timing and pop count.
  task automatic applyStimulus(input int base, input int extra, input int exp_done,
                               input int spur_at, input bit with_clean);
    int p0, w0, n;
    bit got, spur_sent;
    preload(base, extra);
    @(negedge clk);
    p0 = pops;
    w0 = writes;
    start = 1'b1;
    conv_tile_clean = with_clean;
    @(negedge clk);
    start = 1'b0;
    conv_tile_clean = 1'b0;
    got = 1'b0;
    spur_sent = 1'b0;
    for (n = 1; n <= 200; n++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      start = 1'b0;
      if (spur_at > 0 && !spur_sent && (pops - p0) == spur_at) begin
        start = 1'b1;
        spur_sent = 1'b1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (!got) begin
      checkOutput("done_timeout", 32'd0, 32'd1);
    end else begin
      if (exp_done >= 0) checkOutput("done_cycle", n, exp_done);
      checkOutput("writes_at_done", writes - w0, WORDS);
      checkOutput("sb_empty_at_done", exp_q.size(), 0);
    end
    repeat (3) @(negedge clk);
    checkOutput("pop_total", pops - p0, WORDS);
    checkOutput("done_held", 32'(done), 32'd1);
    flushFifo();
  endtask

  initial begin
    int p0, n;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkResetOutputs("reset");
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] streaming tile");
    applyStimulus(0, 4, WORDS + 3, 0, 1'b0);

    $display("[TB] release and restart");
    conv_tile_clean = 1'b1;
    @(negedge clk);
    conv_tile_clean = 1'b0;
    checkOutput("done_after_clean", 32'(done), 32'd0);
    @(negedge clk);
    checkOutput("done_stays_low", 32'(done), 32'd0);
    applyStimulus(32'h100, 0, WORDS + 3, 0, 1'b0);

    $display("[TB] restart from DONE with simultaneous clean");
    applyStimulus(32'h200, 2, WORDS + 3, 0, 1'b1);

    $display("[TB] spurious start");
    applyStimulus(32'h300, 0, WORDS + 3, 4, 1'b0);

    $display("[TB] empty stalls");
    stall_en = 1'b1;
    applyStimulus(32'h400, 0, -1, 0, 1'b0);
    stall_en = 1'b0;
    @(negedge clk);

    $display("[TB] mid-tile reset");
    preload(32'h500, 0);
    @(negedge clk);
    p0 = pops;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (n = 0; n < 50 && (pops - p0) < 5; n++) @(negedge clk);
    checkOutput("pops_before_reset", pops - p0, 5);
    rst = 1'b1;
    @(negedge clk);
    checkResetOutputs("midreset");
    rst = 1'b0;
    exp_q.delete();
    flushFifo();
    applyStimulus(32'h600, 3, WORDS + 3, 0, 1'b0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
